sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
- Run-time loadable, multi-bank colour look-up for sprite pixels. It replaces the fixed per-sprite palette ROMs.
- Sits between the sprite ROM index output and the VGA colour mux.
- Holds NUM_PAL palettes of 2^INDEX_W entries each. Adds a 2-stage registered read, transparency keying and a frame-counted hit-flash effect.

Parameters:
- INDEX_W, 4, colour-index width; each palette has 2^INDEX_W entries.
- NUM_PAL, 4, number of palette banks; PAL_W = clog2(NUM_PAL), minimum 1.
- CH_W, 4, bits per colour channel; an entry is 3*CH_W bits, {R,G,B}.
- KEY_INDEX, 0, index treated as transparent when key_en=1.
- FLASH_FRAMES, 8, duration of a hit flash in frame_tick pulses.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for palette load.
- wr_pal  in  PAL_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_color  in  3*CH_W  {R,G,B} to store.
- rd_valid  in  1  pixel lookup request this cycle.
- pal_sel  in  PAL_W  bank to read.
- index  in  INDEX_W  colour index to read.
- key_en  in  1  enable transparency keying.
- frame_tick  in  1  one-cycle pulse per frame (vsync edge).
- flash_start  in  1  start or restart hit flash.
- red, green, blue  out  CH_W each  looked-up colour.
- out_valid  out  1  colour outputs correspond to a request issued 2 cycles earlier.
- transparent  out  1  pixel is keyed out.
- flash_active  out  1  flash currently in progress.

Behaviour:
- Reset, one cycle:
  - Every entry of every bank is set to all-ones red, zero green, all-ones blue (magenta key).
  - Pipeline valids, red/green/blue, transparent, flash_active and the frame counter all clear to 0.
  - wr_en and flash_start are ignored while Reset=1.
- Storage: register array NUM_PAL x 2^INDEX_W x 3*CH_W.
  - Write takes effect at the Clk edge when wr_en=1.
  - wr_pal >= NUM_PAL: write dropped, no other entry modified.
- Read pipeline, latency 2, one lookup per cycle, no stalls:
  - Stage 1 registers the entry {pal_sel,index}, rd_valid, and (key_en && index==KEY_INDEX).
  - pal_sel >= NUM_PAL reads bank 0.
  - Stage 2 applies flash and drives the outputs.
  - out_valid = rd_valid delayed 2 cycles.
  - With out_valid=0, outputs hold their last values.
- Same-cycle read and write to the same entry: read returns the old value (read-before-write). The new value is visible to a read issued the next cycle.
- Transparency: transparent=1 at stage 2 when the keyed flag is set. Colour outputs still carry the stored entry, unaltered by flash.
- Flash state machine, states IDLE and FLASH; frame counter fcnt is clog2(FLASH_FRAMES+1) bits.
  - IDLE -> FLASH on flash_start: fcnt=0, flash_active=1 next cycle.
  - In FLASH, each frame_tick increments fcnt. When fcnt reaches FLASH_FRAMES-1 and frame_tick=1 -> IDLE, flash_active=0 next cycle.
  - flash_start in FLASH restarts the flash: fcnt=0.
  - flash_start and frame_tick in the same cycle: restart wins; fcnt=0.
- Flash colour: while flash_active=1 and fcnt[0]==0, non-transparent stage-2 pixels output all channels = 2^CH_W-1 (white). Odd fcnt outputs the stored colour.
  - Flash state is sampled at stage 2, so the effect switches exactly on the cycle after the flash register changes.
- Reset mid-flash or mid-pipeline: everything returns to reset values next cycle. In-flight lookups are discarded (out_valid=0 for 2 cycles).

Test Plan:
- Reset, then read bank 2 index 5 with rd_valid=1 -> 2 cycles later {F,0,F}, out_valid=1, transparent=0.
- Write bank 1 index 3 = 0x7A5; read bank 1 index 3 same cycle -> old 0xF0F. Read next cycle -> 0x7A5 after 2 cycles.
- key_en=1, read index 0 in any bank -> transparent=1, colour = stored entry. key_en=0 -> transparent=0.
- Stream 16 back-to-back reads of bank 0 indices 0..15 after loading distinct colours -> 16 consecutive out_valid cycles, in order, no gaps.
- flash_start, then 8 frame_ticks, reading a non-key pixel of 0x123:
  - output alternates FFF / 123 per frame, starting with FFF.
  - flash_active drops the cycle after the 8th tick.
  - A flash_start at tick 4 extends the flash to 12 ticks total.
- Assert Reset while flash_active=1 and 2 reads in flight -> next cycle flash_active=0, out_valid=0 for 2 cycles, all entries 0xF0F.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: run-time loadable multi-bank sprite colour look-up.
// Two-stage registered read, transparency keying and a frame-counted
// hit-flash that forces non-transparent pixels to white on even frames.
module sprite_palette_bank #(
  parameter int unsigned INDEX_W      = 4,
  parameter int unsigned NUM_PAL      = 4,
  parameter int unsigned CH_W         = 4,
  parameter int unsigned KEY_INDEX    = 0,
  parameter int unsigned FLASH_FRAMES = 8,
  localparam int unsigned PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [PAL_W-1:0]   wr_pal,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [3*CH_W-1:0]  wr_color,
  input  logic               rd_valid,
  input  logic [PAL_W-1:0]   pal_sel,
  input  logic [INDEX_W-1:0] index,
  input  logic               key_en,
  input  logic               frame_tick,
  input  logic               flash_start,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               out_valid,
  output logic               transparent,
  output logic               flash_active
);

  localparam int unsigned DEPTH  = 1 << INDEX_W;
  localparam int unsigned COL_W  = 3 * CH_W;
  localparam int unsigned FCNT_W = $clog2(FLASH_FRAMES + 1);

  typedef logic [COL_W-1:0] color_t;
  typedef enum logic {IDLE, FLASH} flash_state_e;

  localparam color_t MAGENTA = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}};
  localparam color_t WHITE   = '1;

  // Palette storage
  color_t mem_q [NUM_PAL][DEPTH];
  color_t mem_d [NUM_PAL][DEPTH];

  // Stage 1 registers
  color_t s1_color_q, s1_color_d;
  logic   s1_valid_q, s1_valid_d;
  logic   s1_key_q,   s1_key_d;

  // Stage 2 / output registers
  color_t pix_q, pix_d;
  logic   out_valid_q, out_valid_d;
  logic   transparent_q, transparent_d;

  // Flash state
  flash_state_e      state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [PAL_W-1:0] rd_bank;
  logic             wr_ok;
  logic             flash_on;

  // Palette write: out-of-range banks are dropped
  always_comb begin
    mem_d = mem_q;
    wr_ok = wr_en && (32'(wr_pal) < NUM_PAL);
    if (wr_ok) begin
      mem_d[wr_pal][wr_index] = wr_color;
    end
  end

  // Palette register array, reset fills every entry with magenta
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned p = 0; p < NUM_PAL; p++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[p][i] <= MAGENTA;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Stage 1: read from the pre-write array so a same-cycle write is not seen
  always_comb begin
    rd_bank    = (32'(pal_sel) < NUM_PAL) ? pal_sel : '0;
    s1_color_d = mem_q[rd_bank][index];
    s1_valid_d = rd_valid;
    s1_key_d   = key_en && (index == INDEX_W'(KEY_INDEX));
  end

  // Stage 2: apply flash and key, hold outputs when no valid pixel arrives
  always_comb begin
    flash_on      = (state_q == FLASH) && !fcnt_q[0];
    out_valid_d   = s1_valid_q;
    pix_d         = pix_q;
    transparent_d = transparent_q;
    if (s1_valid_q) begin
      transparent_d = s1_key_q;
      pix_d         = (flash_on && !s1_key_q) ? WHITE : s1_color_q;
    end
  end

  // Flash next-state: restart beats a coincident frame_tick
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (flash_start) begin
          state_d = FLASH;
          fcnt_d  = '0;
        end
      end
      FLASH: begin
        if (flash_start) begin
          fcnt_d = '0;
        end else if (frame_tick) begin
          if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Pipeline and flash state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_color_q    <= '0;
      s1_valid_q    <= 1'b0;
      s1_key_q      <= 1'b0;
      pix_q         <= '0;
      out_valid_q   <= 1'b0;
      transparent_q <= 1'b0;
      state_q       <= IDLE;
      fcnt_q        <= '0;
    end else begin
      s1_color_q    <= s1_color_d;
      s1_valid_q    <= s1_valid_d;
      s1_key_q      <= s1_key_d;
      pix_q         <= pix_d;
      out_valid_q   <= out_valid_d;
      transparent_q <= transparent_d;
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign red          = pix_q[COL_W-1 -: CH_W];
  assign green        = pix_q[2*CH_W-1 -: CH_W];
  assign blue         = pix_q[CH_W-1:0];
  assign out_valid    = out_valid_q;
  assign transparent  = transparent_q;
  assign flash_active = (state_q == FLASH);

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed self-checking bench for sprite_palette_bank (default parameters).
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [3:0]  wr_index;
  logic [11:0] wr_color;
  logic        rd_valid;
  logic [1:0]  pal_sel;
  logic [3:0]  index;
  logic        key_en;
  logic        frame_tick;
  logic        flash_start;
  logic [3:0]  red, green, blue;
  logic        out_valid, transparent, flash_active;
  logic [11:0] rgb;

  int checks   = 0;
  int failures = 0;

  assign rgb = {red, green, blue};

  sprite_palette_bank #(
    .INDEX_W(4), .NUM_PAL(4), .CH_W(4), .KEY_INDEX(0), .FLASH_FRAMES(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_pal(wr_pal),
    .wr_index(wr_index), .wr_color(wr_color), .rd_valid(rd_valid),
    .pal_sel(pal_sel), .index(index), .key_en(key_en),
    .frame_tick(frame_tick), .flash_start(flash_start),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .transparent(transparent), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] p, input logic [3:0] i, input logic [11:0] c);
    wr_en = 1'b1; wr_pal = p; wr_index = i; wr_color = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; wr_en = 1'b1; wr_pal = 2'd1; wr_index = 4'd3; wr_color = 12'h7A5;
    flash_start = 1'b1; rd_valid = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (flash_active !== 1'b0) begin failures++; $display("FAIL reset_flash_active got=%b exp=0", flash_active); end
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    checks++; if (transparent !== 1'b0) begin failures++; $display("FAIL reset_transparent got=%b exp=0", transparent); end
    Reset = 1'b0; wr_en = 1'b0; flash_start = 1'b0; rd_valid = 1'b0;
    step();
    checks++; if (flash_active !== 1'b0) begin failures++; $display("FAIL reset_flash_ignored got=%b exp=0", flash_active); end
  endtask

  task automatic test_default_read();
    pal_sel = 2'd2; index = 4'd5; rd_valid = 1'b1;
    step();
    pal_sel = 2'd1; index = 4'd3;
    step();
    rd_valid = 1'b0;
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL default_rgb got=%h exp=F0F", rgb); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL default_out_valid got=%b exp=1", out_valid); end
    checks++; if (transparent !== 1'b0) begin failures++; $display("FAIL default_transparent got=%b exp=0", transparent); end
    step();
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL write_during_reset_ignored got=%h exp=F0F", rgb); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL default_valid_drop got=%b exp=0", out_valid); end
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL default_hold got=%h exp=F0F", rgb); end
  endtask

  task automatic test_read_before_write();
    wr_en = 1'b1; wr_pal = 2'd1; wr_index = 4'd3; wr_color = 12'h7A5;
    pal_sel = 2'd1; index = 4'd3; rd_valid = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    rd_valid = 1'b0;
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL rbw_old got=%h exp=F0F", rgb); end
    step();
    checks++; if (rgb !== 12'h7A5) begin failures++; $display("FAIL rbw_new got=%h exp=7A5", rgb); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rbw_valid got=%b exp=1", out_valid); end
  endtask

  task automatic test_key();
    do_write(2'd3, 4'd0, 12'h456);
    key_en = 1'b1; pal_sel = 2'd3; index = 4'd0; rd_valid = 1'b1;
    step(); rd_valid = 1'b0; step();
    checks++; if (transparent !== 1'b1) begin failures++; $display("FAIL key_transparent got=%b exp=1", transparent); end
    checks++; if (rgb !== 12'h456) begin failures++; $display("FAIL key_rgb got=%h exp=456", rgb); end
    index = 4'd1; rd_valid = 1'b1;
    step(); rd_valid = 1'b0; step();
    checks++; if (transparent !== 1'b0) begin failures++; $display("FAIL key_other_index got=%b exp=0", transparent); end
    key_en = 1'b0; index = 4'd0; rd_valid = 1'b1;
    step(); rd_valid = 1'b0; step();
    checks++; if (transparent !== 1'b0) begin failures++; $display("FAIL key_disabled got=%b exp=0", transparent); end
    checks++; if (rgb !== 12'h456) begin failures++; $display("FAIL key_disabled_rgb got=%h exp=456", rgb); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  iv;
    logic [11:0] exp;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      do_write(2'd0, iv, {iv, ~iv, iv ^ 4'h5});
    end
    pal_sel = 2'd0;
    for (int i = 0; i < 18; i++) begin
      rd_valid = (i < 16);
      index = 4'(i);
      step();
      if (i >= 1) begin
        checks++;
        if (out_valid !== (i <= 16)) begin
          failures++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i - 1, out_valid, (i <= 16));
        end
        if (i <= 16) begin
          iv = 4'(i - 1);
          exp = {iv, ~iv, iv ^ 4'h5};
          checks++;
          if (rgb !== exp) begin failures++; $display("FAIL b2b_rgb[%0d] got=%h exp=%h", i - 1, rgb, exp); end
        end
      end
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_flash();
    logic [11:0] prev, exp;
    do_write(2'd2, 4'd7, 12'h123);
    pal_sel = 2'd2; index = 4'd7; rd_valid = 1'b1; key_en = 1'b0;
    flash_start = 1'b1; step(); flash_start = 1'b0;
    checks++; if (flash_active !== 1'b1) begin failures++; $display("FAIL flash_start got=%b exp=1", flash_active); end
    step(); step();
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL flash_first got=%h exp=FFF", rgb); end
    prev = 12'hFFF;
    for (int k = 1; k <= 8; k++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      checks++;
      if (flash_active !== (k < 8)) begin failures++; $display("FAIL flash_active_tick%0d got=%b exp=%b", k, flash_active, (k < 8)); end
      checks++;
      if (rgb !== prev) begin failures++; $display("FAIL flash_lag_tick%0d got=%h exp=%h", k, rgb, prev); end
      step();
      exp = (k < 8 && (k % 2) == 0) ? 12'hFFF : 12'h123;
      checks++;
      if (rgb !== exp) begin failures++; $display("FAIL flash_rgb_tick%0d got=%h exp=%h", k, rgb, exp); end
      prev = exp;
    end
    rd_valid = 1'b0; step(); step();
  endtask

  task automatic test_flash_restart();
    pal_sel = 2'd2; index = 4'd7; rd_valid = 1'b1;
    flash_start = 1'b1; step(); flash_start = 1'b0;
    key_en = 1'b1; index = 4'd0; step(); step();
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL flash_keyed_rgb got=%h exp=F0F", rgb); end
    checks++; if (transparent !== 1'b1) begin failures++; $display("FAIL flash_keyed_tr got=%b exp=1", transparent); end
    key_en = 1'b0; index = 4'd7;
    for (int t = 1; t <= 12; t++) begin
      frame_tick = 1'b1; flash_start = (t == 4);
      step();
      frame_tick = 1'b0; flash_start = 1'b0;
      checks++;
      if (flash_active !== (t < 12)) begin failures++; $display("FAIL restart_active_tick%0d got=%b exp=%b", t, flash_active, (t < 12)); end
      if (t == 5) begin
        step();
        checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL restart_rgb_tick5 got=%h exp=123", rgb); end
      end
    end
    rd_valid = 1'b0; step(); step();
  endtask

  task automatic test_reset_mid();
    flash_start = 1'b1; step(); flash_start = 1'b0;
    checks++; if (flash_active !== 1'b1) begin failures++; $display("FAIL mid_flash_on got=%b exp=1", flash_active); end
    pal_sel = 2'd1; index = 4'd3; rd_valid = 1'b1;
    step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; rd_valid = 1'b0;
    checks++; if (flash_active !== 1'b0) begin failures++; $display("FAIL mid_flash_off got=%b exp=0", flash_active); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid0 got=%b exp=0", out_valid); end
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL mid_rgb got=%h exp=000", rgb); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid1 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid2 got=%b exp=0", out_valid); end
    pal_sel = 2'd1; index = 4'd3; rd_valid = 1'b1; step();
    pal_sel = 2'd3; index = 4'd0; step();
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL mid_entry_b1i3 got=%h exp=F0F", rgb); end
    pal_sel = 2'd0; index = 4'd9; step();
    rd_valid = 1'b0;
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL mid_entry_b3i0 got=%h exp=F0F", rgb); end
    step();
    checks++; if (rgb !== 12'hF0F) begin failures++; $display("FAIL mid_entry_b0i9 got=%h exp=F0F", rgb); end
  endtask

  initial begin
    Reset = 1'b0; wr_en = 1'b0; wr_pal = '0; wr_index = '0; wr_color = '0;
    rd_valid = 1'b0; pal_sel = '0; index = '0; key_en = 1'b0;
    frame_tick = 1'b0; flash_start = 1'b0;
    test_reset();
    test_default_read();
    test_read_before_write();
    test_key();
    test_back_to_back();
    test_flash();
    test_flash_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
